// File: rtl/cmd_frame_decoder.sv
// Host byte-stream to command-bus frame decoder: A5, opcode, addr[2], data[4] -> 1-cycle command.
// Optional checksum byte (XOR of the 7 payload bytes) enabled with `define CMD_CHECKSUM_EN.
module cmd_frame_decoder #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           cmd_opcode,
  output logic [15:0]          cmd_addr,
  output logic [31:0]          cmd_data,
  output logic                 cmd_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_OPC, S_ADDR, S_DATA, S_CSUM, S_ISSUE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_OPC, S_ADDR, S_DATA, S_ISSUE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [7:0]             opc_sh_q, opc_sh_d;
  logic [15:0]            addr_sh_q, addr_sh_d;
  logic [31:0]            data_sh_q, data_sh_d;
  logic [7:0]             cmd_opcode_q, cmd_opcode_d;
  logic [15:0]            cmd_addr_q, cmd_addr_d;
  logic [31:0]            cmd_data_q, cmd_data_d;
  logic                   frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  assign busy       = (state_q != S_IDLE) && (state_q != S_ISSUE);
  assign cmd_valid  = (state_q == S_ISSUE);
  assign cmd_opcode = cmd_opcode_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_data   = cmd_data_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    opc_sh_d     = opc_sh_q;
    addr_sh_d    = addr_sh_q;
    data_sh_d    = data_sh_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
`ifdef CMD_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (busy) timer_d = timer_q + 1'b1;

    case (state_q)
      // ISSUE behaves like IDLE so a header can immediately follow a frame
      S_IDLE, S_ISSUE: begin
        state_d = S_IDLE;
        if (rx_valid && rx_data == HEADER) begin
          state_d = S_OPC;
          timer_d = '0;
`ifdef CMD_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_OPC: if (rx_valid) begin
        opc_sh_d   = rx_data;
        byte_cnt_d = 2'd0;
        state_d    = S_ADDR;
`ifdef CMD_CHECKSUM_EN
        csum_d     = csum_q ^ rx_data;
`endif
      end
      S_ADDR: if (rx_valid) begin
        addr_sh_d  = {addr_sh_q[7:0], rx_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CMD_CHECKSUM_EN
        csum_d     = csum_q ^ rx_data;
`endif
        if (byte_cnt_q == 2'd1) begin
          byte_cnt_d = 2'd0;
          state_d    = S_DATA;
        end
      end
      S_DATA: if (rx_valid) begin
        data_sh_d  = {data_sh_q[23:0], rx_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CMD_CHECKSUM_EN
        csum_d     = csum_q ^ rx_data;
`endif
        if (byte_cnt_q == 2'd3) begin
`ifdef CMD_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_ISSUE;
`endif
        end
      end
`ifdef CMD_CHECKSUM_EN
      S_CSUM: if (rx_valid) begin
        if (rx_data == csum_q) begin
          state_d = S_ISSUE;
        end else begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A byte arriving in the expiry cycle takes priority over the timeout
    if (busy && rx_valid) begin
      timer_d = '0;
    end else if (busy && timer_q == TMR_LAST) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end

    if (state_d == S_ISSUE) begin
      cmd_opcode_d = opc_sh_d;
      cmd_addr_d   = addr_sh_d;
      cmd_data_d   = data_sh_d;
    end

    if (frame_err_d && err_count_q != '1) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      opc_sh_q     <= '0;
      addr_sh_q    <= '0;
      data_sh_q    <= '0;
      cmd_opcode_q <= '0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
`ifdef CMD_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      opc_sh_q     <= opc_sh_d;
      addr_sh_q    <= addr_sh_d;
      data_sh_q    <= data_sh_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
`ifdef CMD_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule
